// File: rtl/lfsr_misr_engine.sv
// Galois LFSR / MISR engine for BIST: pattern generation, response compaction,
// lockup recovery, period detection and a signature compare with pass/fail.
module lfsr_misr_engine #(
  parameter int              Length        = 8,
  parameter logic [1:Length] initial_state = 8'h91,
  parameter int              Cnt_width     = 16,
  parameter int              Sig_cycles    = 255
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Load,
  input  logic [1:Length]      Seed,
  input  logic [1:Length]      Taps,
  input  logic                 Start_lfsr,
  input  logic                 Start_misr,
  input  logic                 Stop,
  input  logic                 Enable,
  input  logic [1:Length]      Data_in,
  input  logic [1:Length]      Golden,
  output logic [1:Length]      Y,
  output logic [Cnt_width-1:0] Count,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Pass,
  output logic                 Lockup,
  output logic                 Period_done,
  output logic [1:0]           State_dbg
);

  typedef enum logic [1:0] {IDLE, RUN_LFSR, RUN_MISR, DONE} state_t;

  // A signature length of zero is treated as a single step.
  localparam logic [Cnt_width-1:0] SIG_EFF =
    (Sig_cycles == 0) ? Cnt_width'(1) : Cnt_width'(Sig_cycles);

  state_t                state_q, state_d;
  logic [1:Length]       y_q, y_d, seed_q, seed_d, step_y, d;
  logic [Cnt_width-1:0]  count_q, count_d, count_inc;
  logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic                  lockup_q, lockup_d, period_q, period_d;
  logic                  fb;
  logic                  unused_tap;

  // The top tap bit has no cell to feed.
  assign unused_tap = Taps[Length];
  assign count_inc  = count_q + Cnt_width'(1);

  always_comb begin
    step_y = '0;
    fb     = y_q[Length];
    d      = (state_q == RUN_MISR) ? Data_in : '0;
    step_y[1] = fb ^ d[1];
    for (int k = 2; k <= Length; k++) begin
      step_y[k] = y_q[k-1] ^ (Taps[Length-k+1] & fb) ^ d[k];
    end
  end

  // Start_* are single-cycle requests honoured only in IDLE; Busy reports
  // that a run is in progress and further starts are dropped until IDLE.
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    seed_d   = seed_q;
    count_d  = count_q;
    done_d   = done_q;
    pass_d   = pass_q;
    lockup_d = 1'b0;
    period_d = 1'b0;
    if (Load) begin
      y_d     = Seed;
      seed_d  = Seed;
      count_d = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      state_d = IDLE;
    end else if (Stop) begin
      state_d = IDLE;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start_misr) begin
            state_d = RUN_MISR;
            count_d = '0;
          end else if (Start_lfsr) begin
            state_d = RUN_LFSR;
            count_d = '0;
          end
        end
        RUN_LFSR: begin
          if (Enable) begin
            count_d = count_inc;
            if (y_q == '0) begin
              y_d      = (seed_q != '0) ? seed_q : initial_state;
              lockup_d = 1'b1;
            end else begin
              y_d = step_y;
            end
            period_d = (y_d == seed_q);
          end
        end
        RUN_MISR: begin
          if (Enable) begin
            y_d     = step_y;
            count_d = count_inc;
            if (count_inc == SIG_EFF) begin
              state_d = DONE;
              done_d  = 1'b1;
              pass_d  = (step_y == Golden);
            end
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == RUN_LFSR) || (state_d == RUN_MISR);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      y_q      <= initial_state;
      seed_q   <= initial_state;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      lockup_q <= 1'b0;
      period_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      seed_q   <= seed_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      lockup_q <= lockup_d;
      period_q <= period_d;
    end
  end

  assign Y           = y_q;
  assign Count       = count_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Pass        = pass_q;
  assign Lockup      = lockup_q;
  assign Period_done = period_q;
  assign State_dbg   = state_q;

endmodule

// File: tb/tb_lfsr_misr_engine.sv
// Directed bench for lfsr_misr_engine: Length=8, taps CFh, 4-step signature.
module tb_lfsr_misr_engine;

  localparam int L = 8;
  localparam int CW = 16;
  localparam logic [1:0] S_IDLE = 2'd0, S_LFSR = 2'd1, S_MISR = 2'd2, S_DONE = 2'd3;

  logic          Clock, Reset, Load, Start_lfsr, Start_misr, Stop, Enable;
  logic [1:L]    Seed, Taps, Data_in, Golden, Y;
  logic [CW-1:0] Count;
  logic          Busy, Done, Pass, Lockup, Period_done;
  logic [1:0]    State_dbg;

  int total = 0;
  int bad = 0;

  lfsr_misr_engine #(
    .Length(L), .initial_state(8'h91), .Cnt_width(CW), .Sig_cycles(4)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Load(Load), .Seed(Seed), .Taps(Taps),
    .Start_lfsr(Start_lfsr), .Start_misr(Start_misr), .Stop(Stop),
    .Enable(Enable), .Data_in(Data_in), .Golden(Golden), .Y(Y),
    .Count(Count), .Busy(Busy), .Done(Done), .Pass(Pass), .Lockup(Lockup),
    .Period_done(Period_done), .State_dbg(State_dbg)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [1:L] s);
    Load = 1'b1; Seed = s;
    tick();
    Load = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Load = 0; Start_lfsr = 0; Start_misr = 0; Stop = 0;
    Enable = 0; Seed = '0; Taps = 8'b1100_1111; Data_in = '0; Golden = '0;
    #1;
    check("rst_y", Y, 8'h91);
    check("rst_count", Count, 0);
    check("rst_state", State_dbg, S_IDLE);
    check("rst_flags", {Busy, Done, Pass, Lockup, Period_done}, 5'b0);
    tick();
    Reset = 1'b0;

    // Basic generate: BB then AE
    do_load(8'h91);
    Start_lfsr = 1'b1; tick(); Start_lfsr = 1'b0;
    check("start_state", State_dbg, S_LFSR);
    check("start_busy", Busy, 1'b1);
    check("start_y", Y, 8'h91);
    Enable = 1'b1;
    tick();
    check("gen1_y", Y, 8'hBB);
    check("gen1_count", Count, 1);
    tick();
    check("gen2_y", Y, 8'hAE);
    check("gen2_count", Count, 2);

    // Full period: pulse only at step 255
    do_load(8'h91);
    check("load_no_step_y", Y, 8'h91);
    Start_lfsr = 1'b1; tick(); Start_lfsr = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i < 255) check("period_early", Period_done, 1'b0);
    end
    check("period_pulse", Period_done, 1'b1);
    check("period_y", Y, 8'h91);
    check("period_count", Count, 255);
    tick();
    check("period_clear", Period_done, 1'b0);
    check("period_next_y", Y, 8'hBB);

    // Zero-state lockup recovery
    do_load(8'h00);
    Start_lfsr = 1'b1; tick(); Start_lfsr = 1'b0;
    check("lock_pre_y", Y, 8'h00);
    tick();
    check("lock_y", Y, 8'h91);
    check("lock_pulse", Lockup, 1'b1);
    check("lock_count", Count, 1);
    check("lock_no_period", Period_done, 1'b0);
    tick();
    check("lock_clear", Lockup, 1'b0);
    check("lock_next_y", Y, 8'hBB);

    // Signature pass: data 01,02,04,08 -> BA,5F,D8,64
    Enable = 1'b0;
    do_load(8'h91);
    Start_misr = 1'b1; tick(); Start_misr = 1'b0;
    check("misr_state", State_dbg, S_MISR);
    Golden = 8'h64; Enable = 1'b1;
    Data_in = 8'h01; tick();
    check("misr1_y", Y, 8'hBA);
    check("misr1_count", Count, 1);
    check("misr1_done", Done, 1'b0);
    Data_in = 8'h02; tick();
    check("misr2_y", Y, 8'h5F);
    Data_in = 8'h04; tick();
    check("misr3_y", Y, 8'hD8);
    Data_in = 8'h08; tick();
    check("misr4_y", Y, 8'h64);
    check("misr4_count", Count, 4);
    check("misr4_done", Done, 1'b1);
    check("misr4_pass", Pass, 1'b1);
    check("misr4_state", State_dbg, S_DONE);
    check("misr4_busy", Busy, 1'b0);
    Data_in = 8'hFF; tick(); tick();
    check("done_hold_y", Y, 8'h64);
    check("done_hold_count", Count, 4);
    check("done_hold_flags", {Done, Pass}, 2'b11);
    Stop = 1'b1; tick(); Stop = 1'b0;
    check("stop_state", State_dbg, S_IDLE);
    check("stop_flags", {Done, Pass}, 2'b00);
    check("stop_hold_y", Y, 8'h64);
    check("stop_hold_count", Count, 4);

    // Signature fail with an Enable gap and an ignored Start_lfsr
    Enable = 1'b0;
    do_load(8'h91);
    Start_misr = 1'b1; tick(); Start_misr = 1'b0;
    Enable = 1'b1;
    Data_in = 8'h00; tick();
    check("fail1_y", Y, 8'hBB);
    Data_in = 8'h02; tick();
    check("fail2_y", Y, 8'hAC);
    Enable = 1'b0; Start_lfsr = 1'b1; Data_in = 8'hFF;
    tick(); tick();
    check("gap_y", Y, 8'hAC);
    check("gap_count", Count, 2);
    check("gap_state", State_dbg, S_MISR);
    Start_lfsr = 1'b0; Enable = 1'b1;
    Data_in = 8'h04; tick();
    check("fail3_y", Y, 8'h52);
    Data_in = 8'h08; tick();
    check("fail4_y", Y, 8'h21);
    check("fail4_done", Done, 1'b1);
    check("fail4_pass", Pass, 1'b0);

    // Both starts together pick MISR
    Stop = 1'b1; tick(); Stop = 1'b0;
    Start_lfsr = 1'b1; Start_misr = 1'b1; Enable = 1'b0;
    tick();
    Start_lfsr = 1'b0; Start_misr = 1'b0;
    check("both_start_state", State_dbg, S_MISR);
    check("both_start_count", Count, 0);

    // Asynchronous reset mid-signature at Count=2
    do_load(8'h91);
    Start_misr = 1'b1; tick(); Start_misr = 1'b0;
    Enable = 1'b1;
    Data_in = 8'h01; tick();
    Data_in = 8'h02; tick();
    check("pre_rst_count", Count, 2);
    #2 Reset = 1'b1;
    #1;
    check("arst_y", Y, 8'h91);
    check("arst_count", Count, 0);
    check("arst_state", State_dbg, S_IDLE);
    check("arst_flags", {Busy, Done, Pass, Lockup, Period_done}, 5'b0);
    tick();
    Reset = 1'b0;
    Enable = 1'b0; Data_in = '0;

    // Load beats Stop
    Start_lfsr = 1'b1; tick(); Start_lfsr = 1'b0;
    Enable = 1'b1; tick();
    check("prestop_y", Y, 8'hBB);
    Load = 1'b1; Stop = 1'b1; Seed = 8'h55;
    tick();
    Load = 1'b0; Stop = 1'b0;
    check("loadstop_y", Y, 8'h55);
    check("loadstop_count", Count, 0);
    check("loadstop_state", State_dbg, S_IDLE);
    check("loadstop_busy", Busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
